// File: rtl/dac_update_scheduler.sv
// Sample-rate scheduler for a two-channel SPI DAC. It sends one A (and optionally B) frame per
// sample tick, then strobes LDAC so that both outputs change together.
module dac_update_scheduler #(
  parameter int unsigned TICK_DIV = 3125,
  parameter int unsigned LDAC_LEN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dual_en,
  input  logic [11:0] a_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [11:0] b_data,
  input  logic        b_valid,
  output logic        b_ready,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  input  logic        ser_done,
  output logic        ldac_n,
  output logic        sample_tick,
  output logic        busy,
  output logic        overrun
);

  localparam logic [11:0] TickLast = 12'(TICK_DIV - 1);
  localparam logic [2:0]  LdacLast = 3'(LDAC_LEN);
  localparam logic [11:0] MidScale = 12'h800;
  // Control bits between channel select and sample: BUF=0, GA_n=1, SHDN_n=1.
  localparam logic [2:0]  FrameCtl = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StWaitA,
    StDoneA,
    StLoadB,
    StWaitB,
    StDoneB,
    StLdac
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] tick_cnt_q, tick_cnt_d;
  logic        sample_tick_q, sample_tick_d;
  logic [11:0] hold_a_q, hold_a_d;
  logic [11:0] hold_b_q, hold_b_d;
  logic        pend_a_q, pend_a_d;
  logic        pend_b_q, pend_b_d;
  logic [15:0] frame_data_q, frame_data_d;
  logic        frame_valid_q, frame_valid_d;
  logic        ldac_n_q, ldac_n_d;
  logic [2:0]  ldac_cnt_q, ldac_cnt_d;
  logic        overrun_q, overrun_d;
  logic        a_accept, b_accept;

  // Free-running sample period counter; the tick register lines up with count == TICK_DIV-1.
  always_comb begin
    tick_cnt_d    = (tick_cnt_q == TickLast) ? 12'd0 : tick_cnt_q + 12'd1;
    sample_tick_d = (tick_cnt_d == TickLast);
  end

  // Holding registers: an accept in a LOAD cycle keeps the new sample pending for next period.
  always_comb begin
    a_accept = a_valid && !pend_a_q;
    b_accept = b_valid && !pend_b_q;
    hold_a_d = a_accept ? a_data : hold_a_q;
    hold_b_d = b_accept ? b_data : hold_b_q;
    pend_a_d = a_accept || (pend_a_q && (state_q != StLoadA));
    pend_b_d = b_accept || (pend_b_q && (state_q != StLoadB));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample_tick_q) state_d = StLoadA;
      StLoadA: state_d = StWaitA;
      StWaitA: if (frame_ready) state_d = StDoneA;
      StDoneA: if (ser_done) state_d = dual_en ? StLoadB : StLdac;
      StLoadB: state_d = StWaitB;
      StWaitB: if (frame_ready) state_d = StDoneB;
      StDoneB: if (ser_done) state_d = StLdac;
      StLdac:  if (ldac_cnt_q == LdacLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy          = (state_q != StIdle);
    a_ready       = !pend_a_q;
    b_ready       = !pend_b_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    unique case (state_q)
      StLoadA: begin
        frame_data_d  = {1'b0, FrameCtl, hold_a_q};
        frame_valid_d = 1'b1;
      end
      StLoadB: begin
        frame_data_d  = {1'b1, FrameCtl, hold_b_q};
        frame_valid_d = 1'b1;
      end
      StWaitA, StWaitB: if (frame_ready) frame_valid_d = 1'b0;
      default: ;
    endcase
    // The LDAC state lasts LDAC_LEN+1 cycles; the registered strobe lags it by one cycle.
    ldac_cnt_d = (state_q == StLdac) ? ldac_cnt_q + 3'd1 : 3'd0;
    ldac_n_d   = !((state_q == StLdac) && (ldac_cnt_q < LdacLast));
    overrun_d  = overrun_q || (sample_tick_q && (state_q != StIdle));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q    <= 12'd0;
      sample_tick_q <= 1'b0;
      hold_a_q      <= MidScale;
      hold_b_q      <= MidScale;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      frame_data_q  <= 16'h0000;
      frame_valid_q <= 1'b0;
      ldac_n_q      <= 1'b1;
      ldac_cnt_q    <= 3'd0;
      overrun_q     <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      sample_tick_q <= sample_tick_d;
      hold_a_q      <= hold_a_d;
      hold_b_q      <= hold_b_d;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      ldac_n_q      <= ldac_n_d;
      ldac_cnt_q    <= ldac_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign ldac_n      = ldac_n_q;
  assign sample_tick = sample_tick_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: an event-scheduled model of the update sequence is compared
// with the DUT every cycle, plus literal pins on the frames and strobes it predicts.
module tb_dac_update_scheduler;

  localparam int TD = 100;
  localparam int LL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dual_en = 1'b0;
  logic [11:0] a_data = 12'd0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [11:0] b_data = 12'd0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        ser_done = 1'b0;
  logic        ldac_n;
  logic        sample_tick;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  dac_update_scheduler #(.TICK_DIV(TD), .LDAC_LEN(LL)) dut (
    .clk(clk), .reset(reset), .dual_en(dual_en),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .ser_done(ser_done), .ldac_n(ldac_n), .sample_tick(sample_tick),
    .busy(busy), .overrun(overrun)
  );

  int total = 0;
  int bad = 0;
  int n = 0;

  // Model: expected outputs for cycle n plus scheduled future events (cycle numbers, -1 = none).
  bit          m_busy, m_fv, m_ldac_n, m_pend_a, m_pend_b, m_overrun;
  logic [15:0] m_fd;
  logic [11:0] m_hold_a, m_hold_b;
  int          load_at, load_ch, cur_ch, await_from, await_ch, lo_start, idle_at, done_at;

  // Stimulus knobs
  int          ready_mode, offer_mode, stall_left, ser_lat;
  bit          lat_rand, dual_rand, dual_fix, stray_en, oa_left, ob_left;
  logic [11:0] oa_val, ob_val;

  // Logs for the literal pins
  int mlog[$];
  int vlen[$];
  int lw[$];
  int gap[$];
  int vrun, lrun, last_done;
  bit prev_ldac;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, n, act, exp);
    end
  endtask

  function automatic logic [15:0] mkframe(input int ch, input logic [11:0] s);
    return 16'(ch * 32768 + 'h3000 + int'(s));
  endfunction

  task automatic model_reset();
    n = 0;
    m_busy = 0; m_fv = 0; m_ldac_n = 1; m_pend_a = 0; m_pend_b = 0; m_overrun = 0;
    m_fd = 16'h0000; m_hold_a = 12'h800; m_hold_b = 12'h800;
    load_at = -1; load_ch = 0; cur_ch = 0; await_from = -1; await_ch = 0;
    lo_start = -1; idle_at = -1; done_at = -1;
    vrun = 0; lrun = 0; last_done = -100; prev_ldac = 1;
  endtask

  task automatic clear_logs();
    mlog.delete(); vlen.delete(); lw.delete(); gap.delete();
  endtask

  task automatic compare();
    check("sample_tick", 32'(sample_tick), 32'((n % TD) == TD - 1));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_data", 32'(frame_data), 32'(m_fd));
    check("ldac_n", 32'(ldac_n), 32'(m_ldac_n));
    check("a_ready", 32'(a_ready), 32'(!m_pend_a));
    check("b_ready", 32'(b_ready), 32'(!m_pend_b));
    check("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  task automatic drive();
    ser_done = 1'b0;
    if (done_at >= 0 && done_at == n) begin
      ser_done = 1'b1;
      done_at = -1;
    end else if (stray_en && done_at < 0 && $urandom_range(15) == 0) begin
      ser_done = 1'b1;
    end
    case (ready_mode)
      1: frame_ready = 1'($urandom_range(1));
      2: begin
        frame_ready = 1'b1;
        if (m_fv && stall_left > 0) begin frame_ready = 1'b0; stall_left--; end
      end
      3: begin
        frame_ready = 1'b1;
        if (m_fv && m_fd[15] && stall_left > 0) begin frame_ready = 1'b0; stall_left--; end
      end
      default: frame_ready = 1'b1;
    endcase
    dual_en = dual_rand ? 1'($urandom_range(1)) : dual_fix;
    a_data = 12'($urandom);
    b_data = 12'($urandom);
    case (offer_mode)
      1: begin
        a_valid = ($urandom_range(3) == 0);
        b_valid = ($urandom_range(3) == 0);
      end
      2: begin
        a_valid = oa_left; if (oa_left) a_data = oa_val;
        b_valid = ob_left; if (ob_left) b_data = ob_val;
      end
      default: begin a_valid = 1'b0; b_valid = 1'b0; end
    endcase
  endtask

  task automatic observe();
    if (frame_valid === 1'b1) vrun++;
    if (frame_valid === 1'b1 && frame_ready) begin vlen.push_back(vrun); vrun = 0; end
    if (ldac_n === 1'b0) begin
      if (prev_ldac) gap.push_back(n - last_done);
      lrun++;
    end else if (lrun > 0) begin
      lw.push_back(lrun);
      lrun = 0;
    end
    prev_ldac = (ldac_n !== 1'b0);
    if (ser_done) last_done = n;
  endtask

  task automatic model_step();
    bit tick, acc_a, acc_b, hs, start;
    tick  = (n % TD) == TD - 1;
    acc_a = a_valid && !m_pend_a;
    acc_b = b_valid && !m_pend_b;
    hs    = m_fv && frame_ready;
    start = tick && !m_busy;
    if (tick && m_busy) m_overrun = 1'b1;
    if (load_at == n) begin
      m_fd = mkframe(load_ch, (load_ch == 1) ? m_hold_b : m_hold_a);
      m_fv = 1'b1;
      cur_ch = load_ch;
      if (load_ch == 0) m_pend_a = 1'b0; else m_pend_b = 1'b0;
      load_at = -1;
    end else if (hs) begin
      m_fv = 1'b0;
      mlog.push_back(int'(m_fd));
      await_from = n + 1;
      await_ch = cur_ch;
      done_at = n + (lat_rand ? int'($urandom_range(20, 1)) : ser_lat);
    end
    if (acc_a) begin m_hold_a = a_data; m_pend_a = 1'b1; oa_left = 1'b0; end
    if (acc_b) begin m_hold_b = b_data; m_pend_b = 1'b1; ob_left = 1'b0; end
    if (ser_done && await_from >= 0 && n >= await_from) begin
      if (await_ch == 0 && dual_en) begin
        load_at = n + 1;
        load_ch = 1;
      end else begin
        lo_start = n + 2;
        idle_at = n + 2 + LL;
      end
      await_from = -1;
    end
    if (start) begin load_at = n + 1; load_ch = 0; end
    n++;
    m_ldac_n = !(lo_start >= 0 && n >= lo_start && n < idle_at);
    if (n == idle_at) begin m_busy = 1'b0; lo_start = -1; idle_at = -1; end
    if (start) m_busy = 1'b1;
  endtask

  task automatic step();
    compare();
    drive();
    observe();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin step(); k++; end
    check("idle within budget", 32'(m_busy), 32'd0);
  endtask

  task automatic set_modes(input int rm, input int om, input int lat, input bit dual);
    ready_mode = rm; offer_mode = om; ser_lat = lat; dual_fix = dual;
    lat_rand = 0; dual_rand = 0; stray_en = 0; stall_left = 0;
  endtask

  initial begin
    oa_left = 0; ob_left = 0; oa_val = 12'd0; ob_val = 12'd0;
    set_modes(0, 0, 40, 1'b1);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    clear_logs();

    // Idle-input sequences: midscale frames, 2-cycle LDAC, no overrun.
    run(3 * TD);
    check("p1 frame count>=4", 32'(mlog.size() >= 4), 32'd1);
    check("p1 frame A", (mlog.size() > 0) ? mlog[0] : -1, 32'h3800);
    check("p1 frame B", (mlog.size() > 1) ? mlog[1] : -1, 32'hB800);
    check("p1 ldac width", (lw.size() > 0) ? lw[0] : -1, 32'd2);
    check("p1 overrun", 32'(overrun), 32'd0);
    wait_idle(400);
    clear_logs();

    // One offer per channel, then resend of the same values.
    set_modes(0, 2, 40, 1'b1);
    oa_val = 12'h123; ob_val = 12'hABC; oa_left = 1; ob_left = 1;
    run(2 * TD);
    wait_idle(400);
    check("p2 frame0", (mlog.size() > 0) ? mlog[0] : -1, 32'h3123);
    check("p2 frame1", (mlog.size() > 1) ? mlog[1] : -1, 32'hBABC);
    check("p2 frame2", (mlog.size() > 2) ? mlog[2] : -1, 32'h3123);
    check("p2 frame3", (mlog.size() > 3) ? mlog[3] : -1, 32'hBABC);
    clear_logs();

    // Single-channel mode.
    set_modes(0, 2, 40, 1'b0);
    oa_val = 12'hFFF; oa_left = 1;
    run(2 * TD);
    wait_idle(400);
    check("p3 frame count", mlog.size(), 32'd2);
    check("p3 frame0", (mlog.size() > 0) ? mlog[0] : -1, 32'h3FFF);
    check("p3 ser_done to ldac", (gap.size() > 0) ? gap[0] : -1, 32'd2);
    clear_logs();

    // Serializer stalls the A frame for 30 cycles.
    set_modes(2, 0, 20, 1'b1);
    stall_left = 30;
    run(TD);
    wait_idle(400);
    check("p4 A valid length", (vlen.size() > 0) ? vlen[0] : -1, 32'd31);
    check("p4 B valid length", (vlen.size() > 1) ? vlen[1] : -1, 32'd1);
    clear_logs();

    // Randomised traffic.
    set_modes(1, 1, 0, 1'b1);
    lat_rand = 1; dual_rand = 1; stray_en = 1;
    run(2000);
    wait_idle(400);
    clear_logs();

    // Sequence longer than the sample period.
    set_modes(0, 0, 120, 1'b1);
    run(3 * TD);
    wait_idle(600);
    check("p6 overrun", 32'(overrun), 32'd1);
    check("p6 first frame is A", (mlog.size() > 0) ? (mlog[0] >> 15) : -1, 32'd0);
    check("p6 second frame is B", (mlog.size() > 1) ? (mlog[1] >> 15) : -1, 32'd1);
    clear_logs();

    // Asynchronous reset while the B frame is stalled.
    set_modes(3, 1, 40, 1'b1);
    stall_left = 10;
    begin
      int k = 0;
      while (!(m_fv && m_fd[15]) && k < 400) begin step(); k++; end
      check("reached WAIT_B", 32'(m_fv && m_fd[15]), 32'd1);
    end
    check("pre-reset frame_valid", 32'(frame_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async frame_valid", 32'(frame_valid), 32'd0);
    check("async ldac_n", 32'(ldac_n), 32'd1);
    check("async busy", 32'(busy), 32'd0);
    check("async overrun", 32'(overrun), 32'd0);
    check("async frame_data", 32'(frame_data), 32'd0);
    check("async a_ready", 32'(a_ready), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0; ser_done = 1'b0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    set_modes(0, 0, 40, 1'b1);
    model_reset();
    clear_logs();
    run(TD + 10);
    check("post-reset frame", (mlog.size() > 0) ? mlog[0] : -1, 32'h3800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
